// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32 NPC core.
// Halts on ebreak, illegal opcode or request timeout; counts retired instructions.
module npc_ctrl #(
    parameter int          TIMEOUT     = 16,
    parameter int          RESET_HOLD  = 1,
    parameter logic [31:0] INSTRET_RST = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_o,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_reg_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    input  logic        mem_ready_i,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic        halt_o,
    output logic        ill_inst_o,
    output logic        bus_err_o,
    output logic [31:0] instret_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam int         CW        = $clog2(TIMEOUT + RESET_HOLD + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   instret_q, instret_d;
    logic          ill_q, ill_d;
    logic          berr_q, berr_d;
    logic [6:0]    opc;
    logic          is_brk, legal, is_store, is_mem, tmo;

    assign opc      = inst_q[6:0];
    assign is_brk   = inst_q == 32'h00100073;
    // SYSTEM is legal only as ebreak; every other SYSTEM encoding is rejected
    assign legal    = is_brk || (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                             OP_LOAD, OP_STORE, OP_IMM, OP_REG});
    assign is_store = opc == OP_STORE;
    assign is_mem   = is_store || opc == OP_LOAD;
    assign tmo      = cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        ill_d     = ill_q;
        berr_d    = berr_q;
        case (state_q)
            S_IDLE: begin
                state_d = (cnt_q == CW'(RESET_HOLD - 1)) ? S_FETCH : S_IDLE;
                cnt_d   = (cnt_q == CW'(RESET_HOLD - 1)) ? '0 : cnt_q + 1'b1;
            end
            S_FETCH: begin
                if (inst_valid_i) begin
                    inst_d  = inst_i;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (tmo) begin
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                ill_d   = !legal;
                state_d = (is_brk || !legal) ? S_HALT : S_EXEC;
            end
            S_EXEC: state_d = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end else if (tmo) begin
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            inst_q    <= '0;
            instret_q <= INSTRET_RST;
            ill_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            ill_q     <= ill_d;
            berr_q    <= berr_d;
        end
    end

    assign inst_req_o = state_q == S_FETCH;
    assign mem_req_o  = state_q == S_MEM;
    assign mem_we_o   = mem_req_o && is_store;
    assign pc_we_o    = state_q == S_WB;
    assign rf_we_o    = pc_we_o && !(opc == OP_BRANCH || is_store) && inst_q[11:7] != 5'd0;
    assign halt_o     = state_q == S_HALT;
    assign inst_reg_o = inst_q;
    assign ill_inst_o = ill_q;
    assign bus_err_o  = berr_q;
    assign instret_o  = instret_q;
endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: vector table, hand sequences and random programs checked against a transaction-level model.
module tb_npc_ctrl;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] EBREAK  = 32'h00100073;
    localparam int E_RET = 0, E_BRK = 1, E_ILL = 2, E_FTO = 3, E_MTO = 4;
    // outs bit order: {inst_req, mem_req, mem_we, rf_we, pc_we, halt, ill_inst, bus_err}
    localparam logic [7:0] O_REQ = 8'h80, O_MREQ = 8'h40, O_MWE = 8'h20, O_RF = 8'h10;
    localparam logic [7:0] O_PC = 8'h08, O_HALT = 8'h04, O_ILL = 8'h02, O_BERR = 8'h01;

    typedef struct {
        logic [31:0] ins;
        int          fd;
        int          md;
        int          e_end;
        logic        e_mem;
        logic        e_we;
        logic        e_rf;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, inst_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_req, mem_req, mem_we, rf_we, pc_we, halt, ill_inst, bus_err;
    logic [31:0] inst_reg, instret;
    logic        w_inst_req, w_mem_req, w_mem_we, w_rf_we, w_pc_we, w_halt, w_ill, w_berr;
    logic [31:0] w_inst_reg, w_instret;
    logic [7:0]  outs, w_outs;
    logic [31:0] exp_ret, exp_ireg;
    int          n_chk = 0, n_fail = 0;
    vec_t        tbl[14];
    logic [6:0]  ops[10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

    npc_ctrl #(.TIMEOUT(TIMEOUT), .RESET_HOLD(1)) dut (
        .clk(clk), .rst(rst), .inst_req_o(inst_req), .inst_valid_i(inst_valid), .inst_i(inst),
        .inst_reg_o(inst_reg), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_ready_i(mem_ready),
        .rf_we_o(rf_we), .pc_we_o(pc_we), .halt_o(halt), .ill_inst_o(ill_inst),
        .bus_err_o(bus_err), .instret_o(instret)
    );

    // Pre-retired copy: starts at 0xFFFFFFFF so its first retirement wraps to 0
    npc_ctrl #(.TIMEOUT(TIMEOUT), .RESET_HOLD(1), .INSTRET_RST(32'hFFFFFFFF)) dut_w (
        .clk(clk), .rst(rst), .inst_req_o(w_inst_req), .inst_valid_i(inst_valid), .inst_i(inst),
        .inst_reg_o(w_inst_reg), .mem_req_o(w_mem_req), .mem_we_o(w_mem_we), .mem_ready_i(mem_ready),
        .rf_we_o(w_rf_we), .pc_we_o(w_pc_we), .halt_o(w_halt), .ill_inst_o(w_ill),
        .bus_err_o(w_berr), .instret_o(w_instret)
    );

    assign outs   = {inst_req, mem_req, mem_we, rf_we, pc_we, halt, ill_inst, bus_err};
    assign w_outs = {w_inst_req, w_mem_req, w_mem_we, w_rf_we, w_pc_we, w_halt, w_ill, w_berr};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // One clock: check the settled outputs, then drive inputs for the coming edge
    task automatic cyc(input logic [7:0] eo, input logic ev, input logic [31:0] iv, input logic rdy);
        @(negedge clk);
        chk("outs", 32'(outs), 32'(eo));
        chk("outs_w", 32'(w_outs), 32'(eo));
        chk("instret", instret, exp_ret);
        chk("instret_wrap", w_instret, exp_ret + 32'hFFFFFFFF);
        chk("inst_reg", inst_reg, exp_ireg);
        chk("inst_reg_w", w_inst_reg, exp_ireg);
        inst_valid = ev;
        inst       = iv;
        mem_ready  = rdy;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        inst_valid = rb();
        inst       = $urandom;
        mem_ready  = rb();
        @(negedge clk);
        exp_ret  = '0;
        exp_ireg = '0;
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_inst_reg", inst_reg, 32'd0);
        chk("rst_instret_wrap", w_instret, 32'hFFFFFFFF);
        rst        = 1'b0;
        inst_valid = rb();
        mem_ready  = rb();
    endtask

    task automatic halt_chk(input logic [7:0] cause);
        for (int i = 0; i < 4; i++) cyc(O_HALT | cause, rb(), $urandom, rb());
    endtask

    // Expected cycle sequence of one instruction, entered with the FSM about to show FETCH
    task automatic run_inst(input logic [31:0] ins, input int fd, input int md, input int e_end,
                            input logic e_mem, input logic e_we, input logic e_rf);
        int nf;
        int nm;
        nf = (e_end == E_FTO) ? TIMEOUT : fd + 1;
        for (int i = 0; i < nf; i++) begin
            logic v;
            v = (e_end != E_FTO) && (i == nf - 1);
            cyc(O_REQ, v, v ? ins : $urandom, rb());
        end
        if (e_end == E_FTO) begin
            halt_chk(O_BERR);
            return;
        end
        exp_ireg = ins;
        cyc(8'h00, rb(), $urandom, rb());
        if (e_end == E_BRK) begin
            halt_chk(8'h00);
            return;
        end
        if (e_end == E_ILL) begin
            halt_chk(O_ILL);
            return;
        end
        cyc(8'h00, rb(), $urandom, rb());
        if (e_mem) begin
            nm = (e_end == E_MTO) ? TIMEOUT : md + 1;
            for (int i = 0; i < nm; i++)
                cyc(O_MREQ | (e_we ? O_MWE : 8'h00), rb(), $urandom, (e_end != E_MTO) && (i == nm - 1));
            if (e_end == E_MTO) begin
                halt_chk(O_BERR);
                return;
            end
        end
        cyc(O_PC | (e_rf ? O_RF : 8'h00), rb(), $urandom, rb());
        exp_ret++;
    endtask

    function automatic int model_end(input logic [31:0] ins, input int fd, input int md);
        bit found = 0;
        foreach (ops[k]) if (ops[k] == ins[6:0]) found = 1;
        if (fd >= TIMEOUT) return E_FTO;
        if (ins == EBREAK) return E_BRK;
        if (!found || ins[6:0] == 7'b1110011) return E_ILL;
        if ((ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) && md >= TIMEOUT) return E_MTO;
        return E_RET;
    endfunction

    initial begin
        tbl[0]  = '{32'h00500093, 0, 0, E_RET, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{32'h0000A103, 0, 3, E_RET, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'h0020A023, 1, 0, E_RET, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{32'h00000063, 2, 0, E_RET, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h00000013, 0, 0, E_RET, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h12345237, 15, 0, E_RET, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{32'h008000EF, 0, 0, E_RET, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{32'h00012283, 0, 15, E_RET, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{32'h002081B3, 0, 0, E_RET, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{EBREAK, 0, 0, E_BRK, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'h0000007F, 0, 0, E_ILL, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'h00000073, 1, 0, E_ILL, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{32'h00500093, 16, 0, E_FTO, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{32'h0020A023, 0, 16, E_MTO, 1'b1, 1'b1, 1'b0};
        exp_ret  = '0;
        exp_ireg = '0;
        do_reset();
        foreach (tbl[i]) begin
            run_inst(tbl[i].ins, tbl[i].fd, tbl[i].md, tbl[i].e_end, tbl[i].e_mem, tbl[i].e_we, tbl[i].e_rf);
            if (tbl[i].e_end != E_RET) do_reset();
        end
        // reset while a load waits in MEM
        cyc(O_REQ, 1'b1, 32'h0000A103, 1'b0);
        exp_ireg = 32'h0000A103;
        cyc(8'h00, 1'b0, '0, 1'b0);
        cyc(8'h00, 1'b0, '0, 1'b0);
        cyc(O_MREQ, 1'b0, '0, 1'b0);
        cyc(O_MREQ, 1'b0, '0, 1'b0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            int r, fd, md, e;
            logic m, w, f;
            r   = $urandom_range(0, 19);
            ins = $urandom;
            if (r == 0) ins = EBREAK;
            else if (r > 2) ins[6:0] = ops[$urandom_range(0, 9)];
            fd = ($urandom_range(0, 29) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 4);
            md = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 4);
            e  = model_end(ins, fd, md);
            m  = ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011;
            w  = ins[6:0] == 7'b0100011;
            f  = !(ins[6:0] == 7'b1100011 || w) && ins[11:7] != 5'd0;
            run_inst(ins, fd, md, e, m, w, f);
            if (e != E_RET) do_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
